// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN dataflow channel blocks.
// Holds the default sample width and the delta-decoder state encoding.
package kpn_pkg;

  localparam int KPN_DATA_WIDTH = 16;

  typedef enum logic {
    DD_SEED = 1'b0,
    DD_RUN  = 1'b1
  } dd_state_t;

endpackage

// File: rtl/kpn_sync_fifo.sv
// Small synchronous FIFO for KPN channels; the head entry is visible combinationally.
// Storage is cleared on reset so the head reads zero until the first push.
module kpn_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (i_reset) begin
          r_mem[gi] <= '0;
        end else if (w_push && (r_wr_ptr[AW-1:0] == AW'(gi))) begin
          r_mem[gi] <= i_push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/delta_decoder_module.sv
// Delta decoder: rebuilds absolute samples from a framed stream of seeds and deltas
// by modular accumulation, with valid/ready on both sides and a small output FIFO.
module delta_decoder_module
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = KPN_DATA_WIDTH,
  parameter int FRAME_LEN  = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_resync,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_first,
  output logic [15:0]           o_frame_count
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  dd_state_t             r_state;
  dd_state_t             w_state_next;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_next;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic [15:0]           r_frame_count;
  logic [15:0]           w_frame_next;
  logic                  r_resync_pending;
  logic                  w_pending_next;
  logic                  r_rst_hold;

  logic                  w_accept;
  logic                  w_seed;
  logic                  w_first;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_sample;
  logic [DATA_WIDTH:0]   w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;

  // in_ready is purely registered: blocked in the cycle after reset and while full.
  assign o_in_ready    = !w_full && !r_rst_hold;
  assign w_accept      = i_in_valid && o_in_ready;
  assign w_seed        = (r_state == DD_SEED) || r_resync_pending || i_resync;
  assign w_sum         = r_acc + i_in_data;
  assign o_out_valid   = !w_empty;
  assign w_pop         = o_out_valid && i_out_ready;
  assign o_out_first   = w_head[DATA_WIDTH];
  assign o_out_data    = w_head[DATA_WIDTH-1:0];
  assign o_frame_count = r_frame_count;

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_acc_next     = r_acc;
    w_frame_next   = r_frame_count;
    w_pending_next = r_resync_pending || i_resync;
    w_first        = 1'b0;
    w_sample       = w_sum;
    if (w_accept) begin
      if (w_seed) begin
        w_first        = 1'b1;
        w_sample       = i_in_data;
        w_pending_next = 1'b0;
        if (FRAME_LEN == 1) begin
          w_state_next = DD_SEED;
          w_count_next = '0;
          w_frame_next = r_frame_count + 16'd1;
        end else begin
          w_state_next = DD_RUN;
          w_count_next = CNT_W'(1);
        end
      end else if (r_count == LAST_IDX) begin
        w_state_next = DD_SEED;
        w_count_next = '0;
        w_frame_next = r_frame_count + 16'd1;
      end else begin
        w_count_next = r_count + 1'b1;
      end
      w_acc_next = w_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state          <= DD_SEED;
      r_count          <= '0;
      r_acc            <= '0;
      r_frame_count    <= '0;
      r_resync_pending <= 1'b0;
      r_rst_hold       <= 1'b1;
    end else begin
      r_state          <= w_state_next;
      r_count          <= w_count_next;
      r_acc            <= w_acc_next;
      r_frame_count    <= w_frame_next;
      r_resync_pending <= w_pending_next;
      r_rst_hold       <= 1'b0;
    end
  end

  kpn_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_push      (w_accept),
    .i_push_data ({w_first, w_sample}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

endmodule

// File: tb/tb_delta_decoder_module.sv
// Scoreboard bench for delta_decoder_module: FRAME_LEN=4 main instance and a FRAME_LEN=1 instance.
module tb_delta_decoder_module;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, resync = 1'b0;
  logic [15:0] in_data = '0, out_data;
  logic        out_valid, out_ready = 1'b0, out_first;
  logic [15:0] frame_count;

  logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_first_b;
  logic [15:0] in_data_b = '0, out_data_b, frame_count_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp_qb[$];
  logic [16:0] mon_e, mon_eb;

  delta_decoder_module #(.DATA_WIDTH(16), .FRAME_LEN(4), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_resync(resync), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_out_first(out_first),
    .o_frame_count(frame_count)
  );

  delta_decoder_module #(.DATA_WIDTH(16), .FRAME_LEN(1), .FIFO_DEPTH(2)) u_dut_fl1 (
    .clk(clk), .i_reset(reset), .i_in_valid(in_valid_b), .o_in_ready(in_ready_b),
    .i_in_data(in_data_b), .i_resync(1'b0), .o_out_valid(out_valid_b),
    .i_out_ready(1'b1), .o_out_data(out_data_b), .o_out_first(out_first_b),
    .o_frame_count(frame_count_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired, required event not seen", name);
  endtask

  // Monitors: pop expected {first,data} whenever a sample is issued.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_sample");
      end else begin
        mon_e = exp_q.pop_front();
        chk("sample", {15'd0, out_first, out_data}, {15'd0, mon_e});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid_b) begin
      if (exp_qb.size() == 0) begin
        fail_now("unexpected_sample_fl1");
      end else begin
        mon_eb = exp_qb.pop_front();
        chk("sample_fl1", {15'd0, out_first_b, out_data_b}, {15'd0, mon_eb});
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [15:0] e, input logic f, input logic rs);
    in_valid = 1'b1;
    in_data  = d;
    resync   = rs;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({f, e});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        resync   = 1'b0;
        chk("valid_after_accept", {31'd0, out_valid}, 32'd1);
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    resync   = 1'b0;
    fail_now("accept_timeout");
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_qb.delete();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    chk("rst_out_first", {31'd0, out_first}, 0);
    chk("rst_frame_count", {16'd0, frame_count}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", {31'd0, in_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] bp_words[4];
  logic [15:0] bp_exp[4];
  int          bp_idx;
  logic        bp_acc;
  logic [15:0] fl1_words[3];

  initial begin
    do_reset();

    // Basic reconstruction, one full frame
    out_ready = 1'b1;
    send(16'd100, 16'd100, 1'b1, 1'b0);
    send(16'd5, 16'd105, 1'b0, 1'b0);
    send(16'hFFFD, 16'd102, 1'b0, 1'b0);
    send(16'd0, 16'd102, 1'b0, 1'b0);
    drain();
    chk("frames_after_t1", {16'd0, frame_count}, 1);

    // Modular wrap; second seed forced by resync coincident with accept
    send(16'hFFFE, 16'hFFFE, 1'b1, 1'b0);
    send(16'd3, 16'h0001, 1'b0, 1'b0);
    send(16'd2, 16'd2, 1'b1, 1'b1);
    send(16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    drain();
    chk("frames_after_wrap", {16'd0, frame_count}, 1);

    // Standalone resync pulse after word 2 aborts the frame
    send(16'd1, 16'h0000, 1'b0, 1'b0);
    resync = 1'b1;
    @(posedge clk);
    #1;
    resync = 1'b0;
    send(16'd500, 16'd500, 1'b1, 1'b0);
    drain();
    chk("frames_after_abort", {16'd0, frame_count}, 1);
    send(16'd1, 16'd501, 1'b0, 1'b0);
    send(16'd2, 16'd503, 1'b0, 1'b0);
    send(16'd3, 16'd506, 1'b0, 1'b0);
    drain();
    chk("frames_after_resync_frame", {16'd0, frame_count}, 2);

    // Backpressure with continuous in_valid
    bp_words = '{16'd10, 16'd1, 16'd1, 16'd1};
    bp_exp   = '{16'd10, 16'd11, 16'd12, 16'd13};
    out_ready = 1'b0;
    bp_idx = 0;
    in_valid = 1'b1;
    in_data = bp_words[0];
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      bp_acc = in_ready && (bp_idx < 4);
      if (bp_acc) exp_q.push_back({(bp_idx == 0), bp_exp[bp_idx]});
      @(posedge clk);
      #1;
      if (bp_acc) bp_idx++;
      in_valid = (bp_idx < 4);
      if (bp_idx < 4) in_data = bp_words[bp_idx];
    end
    chk("bp_accepts", bp_idx, 2);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_hold_data", {16'd0, out_data}, 10);
    chk("bp_hold_first", {31'd0, out_first}, 1);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && bp_idx < 4; cyc++) begin
      @(negedge clk);
      bp_acc = in_ready && (bp_idx < 4);
      if (bp_acc) exp_q.push_back({(bp_idx == 0), bp_exp[bp_idx]});
      @(posedge clk);
      #1;
      if (bp_acc) bp_idx++;
      in_valid = (bp_idx < 4);
      if (bp_idx < 4) in_data = bp_words[bp_idx];
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", bp_idx, 4);
    drain();
    chk("frames_after_bp", {16'd0, frame_count}, 3);

    // Two back-to-back frames of FRAME_LEN=4
    send(16'd7, 16'd7, 1'b1, 1'b0);
    send(16'd1, 16'd8, 1'b0, 1'b0);
    send(16'd1, 16'd9, 1'b0, 1'b0);
    send(16'd1, 16'd10, 1'b0, 1'b0);
    send(16'd20, 16'd20, 1'b1, 1'b0);
    send(16'hFFFF, 16'd19, 1'b0, 1'b0);
    send(16'hFFFF, 16'd18, 1'b0, 1'b0);
    send(16'hFFFF, 16'd17, 1'b0, 1'b0);
    drain();
    chk("frames_after_two", {16'd0, frame_count}, 5);

    // Reset mid-frame with a full FIFO drops buffered samples
    out_ready = 1'b0;
    send(16'd1000, 16'd1000, 1'b1, 1'b0);
    send(16'd1, 16'd1001, 1'b0, 1'b0);
    do_reset();
    out_ready = 1'b1;
    send(16'd42, 16'd42, 1'b1, 1'b0);
    send(16'd8, 16'd50, 1'b0, 1'b0);
    drain();
    chk("frames_after_mid_reset", {16'd0, frame_count}, 0);

    // FRAME_LEN=1: every word is a seed and completes a frame
    fl1_words = '{16'd5, 16'd6, 16'd7};
    for (int w = 0; w < 3; w++) begin
      in_valid_b = 1'b1;
      in_data_b  = fl1_words[w];
      bp_acc = 1'b0;
      for (int t = 0; t < 20 && !bp_acc; t++) begin
        @(negedge clk);
        bp_acc = in_ready_b;
        if (bp_acc) exp_qb.push_back({1'b1, fl1_words[w]});
        @(posedge clk);
        #1;
      end
      in_valid_b = 1'b0;
      if (!bp_acc) fail_now("fl1_accept_timeout");
    end
    repeat (3) @(posedge clk);
    #1;
    chk("fl1_queue_empty", exp_qb.size(), 0);
    chk("fl1_frame_count", {16'd0, frame_count_b}, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
